// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl
// Serializes a 16-bit word through an external 16:1 multiplexer.
// The word is parked on y16, sel walks across all sixteen inputs, and the
// mux output is sampled back one bit per cycle.
// Reported alongside the bits:
//   - a one-cycle done pulse with the last bit
//   - the running XOR parity of the sampled bits
// The scan can be frozen cycle-by-cycle with hold.
module mux16_scan_ctrl #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hold,
    input  logic [15:0] data_in,
    input  logic        mux_q,
    output logic [15:0] y16,
    output logic [3:0]  sel,
    output logic        ser_out,
    output logic        ser_valid,
    output logic        busy,
    output logic        done,
    output logic        parity
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Scan starts at input 0 for LSB-first, at input 15 for MSB-first.
    localparam logic [3:0] FIRST_SEL = MSB_FIRST ? 4'd15 : 4'd0;

    state_t     state_r;
    logic [3:0] cnt_r;

    // Fold one sampled bit into the running parity.
    function automatic logic parity_step(input logic acc, input logic sample);
        parity_step = acc ^ sample;
    endfunction

    // Next mux input in scan order; never called on the last sample, so no wrap mid-scan.
    function automatic logic [3:0] next_sel(input logic [3:0] cur);
        if (MSB_FIRST) begin
            next_sel = cur - 4'd1;
        end else begin
            next_sel = cur + 4'd1;
        end
    endfunction

    // Scan FSM with all outputs registered; reset is synchronous and wins over start/hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            y16       <= 16'h0000;
            sel       <= 4'd0;
            cnt_r     <= 4'd0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            parity    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ser_valid <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        y16     <= data_in;
                        sel     <= FIRST_SEL;
                        cnt_r   <= 4'd0;
                        parity  <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= SCAN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    if (hold) begin
                        // Frozen: sel/cnt/parity/ser_out keep their values, no new bit.
                        ser_valid <= 1'b0;
                    end else begin
                        ser_out   <= mux_q;
                        ser_valid <= 1'b1;
                        parity    <= parity_step(parity, mux_q);
                        cnt_r     <= cnt_r + 4'd1;
                        if (cnt_r == 4'd15) begin
                            // Sixteenth sample: park sel back at the start index.
                            done    <= 1'b1;
                            sel     <= FIRST_SEL;
                            state_r <= DONE;
                        end else begin
                            sel     <= next_sel(sel);
                        end
                    end
                end
                DONE: begin
                    // One settling cycle; start is deliberately not looked at here.
                    ser_valid <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    ser_valid <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// tb_mux16_scan_ctrl
// Self-checking bench for mux16_scan_ctrl.
// Two instances share one set of inputs: LSB-first and MSB-first.
// Each instance has its own behavioural 16:1 mux closing the loop.
module tb_mux16_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        hold;
    logic [15:0] data_in;

    logic        lsb_mux_q,  msb_mux_q;
    logic [15:0] lsb_y16,    msb_y16;
    logic [3:0]  lsb_sel,    msb_sel;
    logic        lsb_ser_out, msb_ser_out;
    logic        lsb_ser_valid, msb_ser_valid;
    logic        lsb_busy,   msb_busy;
    logic        lsb_done,   msb_done;
    logic        lsb_parity, msb_parity;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Behavioural external multiplexers.
    assign lsb_mux_q = lsb_y16[lsb_sel];
    assign msb_mux_q = msb_y16[msb_sel];

    mux16_scan_ctrl #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .data_in(data_in),
        .mux_q(lsb_mux_q), .y16(lsb_y16), .sel(lsb_sel), .ser_out(lsb_ser_out),
        .ser_valid(lsb_ser_valid), .busy(lsb_busy), .done(lsb_done), .parity(lsb_parity)
    );

    mux16_scan_ctrl #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .data_in(data_in),
        .mux_q(msb_mux_q), .y16(msb_y16), .sel(msb_sel), .ser_out(msb_ser_out),
        .ser_valid(msb_ser_valid), .busy(msb_busy), .done(msb_done), .parity(msb_parity)
    );

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_lsb;   // bit i = i-th emitted bit, LSB-first instance
        logic [15:0] exp_msb;   // bit i = i-th emitted bit, MSB-first instance
        logic        exp_par;
        logic [31:0] hold_mask; // bit c set = hold asserted for scan cycle c
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: emission order of the MSB-first scan is the bit-reversed word.
    function automatic logic [15:0] reverse16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = w[15 - i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " lsb outs"}, {7'd0, lsb_y16, lsb_sel, lsb_ser_out, lsb_ser_valid,
                                   lsb_busy, lsb_done, lsb_parity}, 32'd0);
        check({tag, " msb outs"}, {7'd0, msb_y16, msb_sel, msb_ser_out, msb_ser_valid,
                                   msb_busy, msb_done, msb_parity}, 32'd0);
    endtask

    // One full scan from IDLE plus the DONE cycle.
    // noise: 0 quiet, 1 random hold/start/data, 2 start=1 with data_in=0 while busy.
    task automatic do_scan(input logic [15:0] word, input logic [15:0] exp0,
                           input logic [15:0] exp1, input logic exp_par,
                           input logic [31:0] hold_mask, input int noise, input string tag);
        logic [15:0] s0, s1;
        int n0, n1, nh, done_c, done_m;
        logic y16_bad;
        s0 = 16'h0000; s1 = 16'h0000;
        n0 = 0; n1 = 0; nh = 0; done_c = -1; done_m = -1; y16_bad = 1'b0;
        data_in = word; start = 1'b1; hold = 1'b0;
        tick();
        start = 1'b0;
        check({tag, " busy after start"}, {31'd0, lsb_busy & msb_busy}, 32'd1);
        check({tag, " y16 loaded"}, {lsb_y16, msb_y16}, {word, word});
        check({tag, " first sel"}, {24'd0, lsb_sel, msb_sel}, {24'd0, 4'd0, 4'd15});
        for (int c = 1; c <= 60 && done_c < 0; c++) begin
            if (noise == 1) begin
                hold    = ($urandom_range(0, 3) == 0);
                start   = $urandom_range(0, 1);
                data_in = $urandom;
            end else begin
                hold = (c < 32) ? hold_mask[c] : 1'b0;
                if (noise == 2) begin
                    start = 1'b1; data_in = 16'h0000;
                end
            end
            tick();
            if (hold) nh++;
            if (lsb_ser_valid) begin if (n0 < 16) s0[n0] = lsb_ser_out; n0++; end
            if (msb_ser_valid) begin if (n1 < 16) s1[n1] = msb_ser_out; n1++; end
            if (lsb_y16 !== word || msb_y16 !== word) y16_bad = 1'b1;
            if (msb_done) done_m = c;
            if (lsb_done) done_c = c;
        end
        hold = 1'b0;
        check({tag, " done latency"}, done_c, 16 + nh);
        check({tag, " msb done latency"}, done_m, done_c);
        check({tag, " valid count"}, {n0[15:0], n1[15:0]}, {16'd16, 16'd16});
        check({tag, " lsb stream"}, {16'd0, s0}, {16'd0, exp0});
        check({tag, " msb stream"}, {16'd0, s1}, {16'd0, exp1});
        check({tag, " parity"}, {30'd0, lsb_parity, msb_parity}, {30'd0, exp_par, exp_par});
        check({tag, " y16 stable"}, {31'd0, y16_bad}, 32'd0);
        // DONE cycle: start here must be ignored.
        if (noise != 0) begin start = 1'b1; data_in = ~word; end
        tick();
        start = 1'b0; data_in = word;
        check({tag, " idle after done"}, {lsb_busy, lsb_done, lsb_ser_valid,
                                          msb_busy, msb_done, msb_ser_valid}, 32'd0);
        check({tag, " parity/y16 held"}, {lsb_parity, msb_parity, lsb_y16},
              {exp_par, exp_par, word});
    endtask

    vec_t vecs[5];

    initial begin
        int cur_low, dones, valids, nv;
        logic [15:0] w;

        vecs[0] = '{word: 16'h5A3C, exp_lsb: 16'h5A3C, exp_msb: 16'h3C5A, exp_par: 1'b0, hold_mask: 32'h0};
        vecs[1] = '{word: 16'h0001, exp_lsb: 16'h0001, exp_msb: 16'h8000, exp_par: 1'b1, hold_mask: 32'h0};
        vecs[2] = '{word: 16'hFFFF, exp_lsb: 16'hFFFF, exp_msb: 16'hFFFF, exp_par: 1'b0, hold_mask: 32'h0000_0218};
        vecs[3] = '{word: 16'h1234, exp_lsb: 16'h1234, exp_msb: 16'h2C48, exp_par: 1'b1, hold_mask: 32'h0001_0002};
        vecs[4] = '{word: 16'h8000, exp_lsb: 16'h8000, exp_msb: 16'h0001, exp_par: 1'b1, hold_mask: 32'h0};

        rst_n = 1'b0; start = 1'b1; hold = 1'b1; data_in = 16'hFFFF;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1; start = 1'b0; hold = 1'b0;
        tick();
        check_all_zero("idle no start");

        // Table-driven scans.
        for (int i = 0; i < 5; i++)
            do_scan(vecs[i].word, vecs[i].exp_lsb, vecs[i].exp_msb, vecs[i].exp_par,
                    vecs[i].hold_mask, 0, $sformatf("vec%0d", i));

        // start re-asserted during SCAN and DONE, then restart right after busy falls.
        do_scan(16'hC0DE, 16'hC0DE, reverse16(16'hC0DE), ^16'hC0DE, 32'h0, 2, "ignore start");
        do_scan(16'h0F0F, 16'h0F0F, 16'hF0F0, 1'b0, 32'h0, 0, "restart");

        // Reset just before the 8th bit, with start/hold also high.
        data_in = 16'hA5A5; start = 1'b1;
        tick();
        start = 1'b0; nv = 0;
        for (int c = 0; c < 40 && nv < 7; c++) begin
            tick();
            if (lsb_ser_valid) nv++;
        end
        check("reset point reached", nv, 7);
        rst_n = 1'b0; start = 1'b1; hold = 1'b1;
        tick();
        check_all_zero("mid-scan reset");
        rst_n = 1'b1; start = 1'b0; hold = 1'b0;
        tick();
        check_all_zero("after reset release");
        do_scan(16'h8000, 16'h8000, 16'h0001, 1'b1, 32'h0, 0, "post reset");

        // Back-to-back scans with start held high.
        start = 1'b1; data_in = 16'hC3A5;
        cur_low = 0; dones = 0; valids = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (lsb_done) dones++;
            if (lsb_ser_valid) valids++;
            if (!lsb_busy) begin
                cur_low++;
                if (dones == 3) break;
            end else if (cur_low > 0) begin
                check("b2b busy low gap", cur_low, 1);
                cur_low = 0;
            end
        end
        start = 1'b0;
        check("b2b done count", dones, 3);
        check("b2b valid count", valids, 48);
        tick();
        check("b2b idle", {31'd0, lsb_busy}, 32'd0);

        // Randomized scans against the reference model.
        for (int k = 0; k < 20; k++) begin
            w = $urandom;
            for (int j = 0; j < $urandom_range(0, 3); j++) tick();
            do_scan(w, w, reverse16(w), ^w, 32'h0, 1, $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
